imem_loader: RTL and testbench

Boot loader feeding the instruction memory's write port from a byte stream, typically a UART receiver.
- Receives a length byte, then N little-endian 32-bit words.
- Writes each word into consecutive imem word addresses starting at 0.
- Holds the CPU in reset until loading completes, then releases it.
- Sits directly upstream of imem and drives its `write`, `addr_in` and `data` inputs.

---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream boot loader driving the imem write port; holds the CPU in reset until loaded.
// Optional trailing XOR checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_write,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] n_q, n_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [23:0]   word_q, word_d;
  logic [CW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic acc;
  logic len_bad;

  assign acc     = rx_valid && rx_ready;
  assign len_bad = (rx_data == 8'd0) ||
                   (32'(rx_data) > 32'(DEPTH));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      S_IDLE: state_d = S_LEN;
      S_LEN: begin
        if (acc) begin
          n_d = CW'(rx_data);
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = rx_data;
`endif
          if (len_bad) begin
            state_d = S_ERROR;
          end else begin
            wcnt_d  = '0;
            bcnt_d  = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          // bytes enter at the top so the first one ends up in [7:0]
          word_d = {rx_data, word_q[23:8]};
          bcnt_d = bcnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_data;
`endif
          if (bcnt_q == 2'd3) begin
            addr_d  = wcnt_q;
            data_d  = {rx_data, word_q};
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wcnt_d = wcnt_q + CW'(1);
        if (wcnt_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (acc) begin
          if (rx_data == csum_q) state_d = S_DONE;
          else                   state_d = S_ERROR;
        end
      end
`endif
      S_DONE: begin
        if (start) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign rx_ready = (state_q == S_LEN) ||
                    (state_q == S_DATA) ||
                    (state_q == S_CHECK);
  assign busy     = rx_ready || (state_q == S_WRITE);
`else
  assign rx_ready = (state_q == S_LEN) ||
                    (state_q == S_DATA);
  assign busy     = rx_ready || (state_q == S_WRITE);
`endif

  assign imem_write = (state_q == S_WRITE);
  assign imem_addr  = 32'(addr_q);
  assign imem_data  = data_q;
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign cpu_rst_n  = (state_q == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a stream-level reference model.
// Define IMEM_LOADER_CHECKSUM_EN for both RTL and bench to cover the checksum build.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_write;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  int n_chk;
  int n_err;

  logic [31:0] got_a[$];
  logic [31:0] got_d[$];
  logic [31:0] dir_w[$];
  logic [31:0] no_w[$];

  imem_loader #(.DEPTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_write(imem_write),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // capture every write strobe; the loader must not offer ready during it
  always @(negedge clk) begin
    if (rst_n && imem_write === 1'b1) begin
      got_a.push_back(imem_addr);
      got_d.push_back(imem_data);
      check("bubble_rdy", 32'(rx_ready), 32'd0);
    end
  end

  task automatic send_bytes(
    input  logic [7:0] b[$],
    input  int         p,
    output bit         ok
  );
    ok = 1'b1;
    foreach (b[i]) begin
      bit acc;
      int t;
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clk);
        rx_valid = ($urandom_range(99) < p);
        rx_data  = rx_valid ? b[i] : 8'($urandom);
        acc      = rx_valid && rx_ready;
        t++;
        if (!acc && t > 300) begin
          check("accept_timeout", 32'(rx_ready), 32'd1);
          rx_valid = 1'b0;
          ok = 1'b0;
          return;
        end
      end
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic load(
    input logic [7:0]  len,
    input logic [31:0] words[$],
    input int          p,
    input bit          bad_ck
  );
    logic [7:0]  q[$];
    logic [31:0] w[$];
    logic [7:0]  x;
    logic [7:0]  by;
    bit          vld;
    bit          ok;
    bit          err_exp;
    int          lat;
    int          lat_exp;
    int          nexp;
    vld = (len != 8'd0) && (len <= 8'd32);
    q.push_back(len);
    x = len;
    if (vld) begin
      for (int i = 0; i < int'(len); i++) begin
        if (i < words.size()) w.push_back(words[i]);
        else                  w.push_back($urandom);
        for (int j = 0; j < 4; j++) begin
          by = w[i][8*j +: 8];
          q.push_back(by);
          x = x ^ by;
        end
      end
    end
    err_exp = !vld;
    lat_exp = vld ? 2 : 1;
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (vld) begin
      q.push_back(x ^ {7'd0, bad_ck});
      err_exp = bad_ck;
      lat_exp = 1;
    end
`endif
    got_a.delete();
    got_d.delete();
    send_bytes(q, p, ok);
    if (!ok) return;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(done || error) && lat < 20);
    check("latency",   32'(lat),       32'(lat_exp));
    check("done",      32'(done),      32'(!err_exp));
    check("error",     32'(error),     32'(err_exp));
    check("cpu_rst_n", 32'(cpu_rst_n), 32'(!err_exp));
    check("busy_end",  32'(busy),      32'd0);
    nexp = vld ? int'(len) : 0;
    check("nwrites", 32'(got_a.size()), 32'(nexp));
    for (int i = 0; i < nexp && i < got_a.size(); i++) begin
      check("waddr", got_a[i], 32'(i));
      check("wdata", got_d[i], w[i]);
    end
  endtask

  task automatic rearm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rearm_cpu_rst", 32'(cpu_rst_n), 32'd0);
    check("rearm_idle",    32'(rx_ready),  32'd0);
    @(negedge clk);
    check("rearm_rdy",     32'(rx_ready),  32'd1);
  endtask

  task automatic hold_error();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      check("err_rdy",  32'(rx_ready), 32'd0);
      check("err_hold", 32'(error),    32'd1);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("err_nowr", 32'(got_a.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"},  32'(rx_ready),   32'd0);
    check({tag, "_wr"},   32'(imem_write), 32'd0);
    check({tag, "_addr"}, imem_addr,       32'd0);
    check({tag, "_data"}, imem_data,       32'd0);
    check({tag, "_cpu"},  32'(cpu_rst_n),  32'd0);
    check({tag, "_busy"}, 32'(busy),       32'd0);
    check({tag, "_done"}, 32'(done),       32'd0);
    check({tag, "_err"},  32'(error),      32'd0);
  endtask

  initial begin
    logic [7:0] part[$];
    bit         ok;
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    dir_w    = '{32'h000007b7, 32'h00078793, 32'h00010737};
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    #1 check("rel_rdy0", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("rel_rdy1", 32'(rx_ready), 32'd1);
    check("rel_busy", 32'(busy),     32'd1);

    load(8'd3, dir_w, 100, 1'b0);
    rearm();
    load(8'd0, no_w, 100, 1'b0);
    hold_error();
    rearm();
    load(8'd33, no_w, 100, 1'b0);
    hold_error();
    rearm();
    load(8'd3, dir_w, 50, 1'b0);
    rearm();

    part = '{8'h03, 8'hb7, 8'h07, 8'h00,
             8'h00, 8'h93, 8'h87};
    send_bytes(part, 80, ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    load(8'd3, dir_w, 70, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    rearm();
    load(8'd1, dir_w, 100, 1'b0);
    rearm();
    load(8'd1, dir_w, 100, 1'b1);
`endif

    rearm();
    load(8'd1, no_w, 100, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] len;
      rearm();
      if (k == 3)      len = 8'(32 + $urandom_range(1, 223));
      else if (k == 5) len = 8'd32;
      else             len = 8'($urandom_range(1, 32));
      load(len, no_w, $urandom_range(30, 100), 1'($urandom_range(1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
